// File: rtl/ram_req_ctrl.sv
// Request controller: FIFO-buffered read/write issue to a single-port RAM,
// read responses tagged with their address after a fixed latency, plus flush/drain.
module ram_req_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              flush_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e            state_q;
    logic              flush_done_q;

    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [PW:0]       cnt_q;

    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic [RD_LAT-1:0] tag_v_q;
    logic [ADDR_W-1:0] tag_a_q [RD_LAT];

    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [15:0]       wr_cnt_q;
    logic [15:0]       rd_cnt_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              hd_wr;
    logic [ADDR_W-1:0] hd_addr;
    logic [DATA_W-1:0] hd_wdata;
    logic              rd_pend;
    logic              drained;

    assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign req_ready  = !fifo_full && (state_q != DRAIN);
    assign push       = req_valid && req_ready;
    assign pop        = !fifo_empty;

    assign {hd_wr, hd_addr, hd_wdata} = fifo_q[rptr_q];

    // A read on the RAM bus this cycle enters the tag pipe at the next edge
    assign rd_pend = ram_en_q && !ram_we_q;
    assign drained = fifo_empty && !rd_pend && (tag_v_q == '0);
    assign busy    = !fifo_empty || rd_pend || (tag_v_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {req_wr, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            ram_en_q    <= pop;
            ram_we_q    <= pop && hd_wr;
            ram_addr_q  <= pop ? hd_addr : '0;
            ram_wdata_q <= (pop && hd_wr) ? hd_wdata : '0;
            if (pop && hd_wr) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_a_q[i] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            rd_cnt_q    <= '0;
        end else begin
            tag_v_q[0] <= rd_pend;
            tag_a_q[0] <= ram_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_a_q[i] <= tag_a_q[i-1];
            end
            rsp_valid_q <= tag_v_q[RD_LAT-1];
            rsp_addr_q  <= tag_v_q[RD_LAT-1] ? tag_a_q[RD_LAT-1] : '0;
            rsp_rdata_q <= tag_v_q[RD_LAT-1] ? ram_rdata : '0;
            if (tag_v_q[RD_LAT-1]) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        flush_done_q <= 1'b1;
                    end else if (push) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        state_q      <= IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flush_done = flush_done_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign wr_cnt     = wr_cnt_q;
    assign rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a 2-cycle-latency RAM model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_ram_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        flush_done;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        rsp_valid;
    logic [7:0]  rsp_addr;
    logic [31:0] rsp_rdata;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic        busy;

    int total  = 0;
    int passes = 0;

    logic [7:0]  qa [$];
    logic [31:0] qd [$];

    logic [31:0] mem [256];
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;

    always #5 clk = ~clk;

    ram_req_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .flush_done (flush_done),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_addr   (rsp_addr),
        .rsp_rdata  (rsp_rdata),
        .wr_cnt     (wr_cnt),
        .rd_cnt     (rd_cnt),
        .busy       (busy)
    );

    // Synchronous RAM, read data valid two cycles after the read strobe
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        r1 <= (ram_en && !ram_we) ? mem[ram_addr] : 32'h0;
        r2 <= r1;
    end
    assign ram_rdata = r2;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            qa.push_back(rsp_addr);
            qd.push_back(rsp_rdata);
        end
    end

    function automatic logic [31:0] exp_d(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [7:0] a,
                        input logic [31:0] d);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = req_ready;
            step();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 40 && qa.size() < n; k++) step();
        chk("rsp_count", 32'(qa.size()), 32'(n));
    endtask

    initial begin
        int pulses;
        int at_pulse;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        flush     = 1'b0;
        repeat (3) step();

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        reset = 1'b1;
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);

        // Write then read the same address
        send(1'b1, 8'h10, 32'hDEADBEEF);
        send(1'b0, 8'h10, 32'h0);
        req_valid = 1'b0;
        chk("wr_ram_en", 32'(ram_en), 32'd1);
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h10);
        chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
        chk("wr_cnt_1", 32'(wr_cnt), 32'd1);
        step();
        chk("rd_ram_en", 32'(ram_en), 32'd1);
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h10);
        step();
        chk("rsp_early1", 32'(rsp_valid), 32'd0);
        step();
        chk("rsp_early2", 32'(rsp_valid), 32'd0);
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_addr", 32'(rsp_addr), 32'h10);
        chk("rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_cnt_1", 32'(rd_cnt), 32'd1);
        step();
        chk("rsp_single", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ram_en", 32'(ram_en), 32'd0);

        // Back-to-back stream: 8 writes then 8 reads
        qa.delete();
        qd.delete();
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h20 + i), exp_d(i));
        for (int i = 0; i < 8; i++) send(1'b0, 8'(8'h20 + i), 32'h0);
        req_valid = 1'b0;
        wait_rsp(8);
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            chk($sformatf("stream_addr%0d", i), 32'(qa[i]), 32'(8'h20 + i));
            chk($sformatf("stream_data%0d", i), qd[i], exp_d(i));
        end
        chk("stream_wr_cnt", 32'(wr_cnt), 32'd9);
        chk("stream_rd_cnt", 32'(rd_cnt), 32'd9);

        // Flush with three reads outstanding
        qa.delete();
        qd.delete();
        send(1'b0, 8'h20, 32'h0);
        send(1'b0, 8'h21, 32'h0);
        req_valid = 1'b1;
        req_addr  = 8'h22;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("drain_ready", 32'(req_ready), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        pulses   = 0;
        at_pulse = -1;
        for (int k = 0; k < 20; k++) begin
            if (flush_done === 1'b1) begin
                pulses++;
                at_pulse = qa.size();
            end
            step();
        end
        chk("flush_pulses", 32'(pulses), 32'd1);
        chk("flush_after_rsp", 32'(at_pulse), 32'd3);
        wait_rsp(3);
        for (int i = 0; i < 3 && i < qa.size(); i++) begin
            chk($sformatf("flush_addr%0d", i), 32'(qa[i]), 32'(8'h20 + i));
            chk($sformatf("flush_data%0d", i), qd[i], exp_d(i));
        end
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd1);

        // Flush while idle
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("idle_flush_done", 32'(flush_done), 32'd1);
        step();
        chk("idle_flush_once", 32'(flush_done), 32'd0);
        chk("idle_flush_ready", 32'(req_ready), 32'd1);

        // Reset with two reads in flight
        send(1'b0, 8'h21, 32'h0);
        send(1'b0, 8'h22, 32'h0);
        req_valid = 1'b0;
        step();
        reset = 1'b0;
        qa.delete();
        qd.delete();
        step();
        step();
        chk("mid_rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (6) step();
        chk("mid_rst_no_rsp", 32'(qa.size()), 32'd0);

        send(1'b1, 8'h30, 32'h0000_0077);
        send(1'b0, 8'h30, 32'h0);
        req_valid = 1'b0;
        wait_rsp(1);
        if (qa.size() > 0) begin
            chk("post_rst_addr", 32'(qa[0]), 32'h30);
            chk("post_rst_data", qd[0], 32'h0000_0077);
        end
        chk("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("post_rst_rd_cnt", 32'(rd_cnt), 32'd1);

        // Write counter wrap
        for (int i = 0; i < 65534; i++) send(1'b1, i[7:0], 32'(i));
        req_valid = 1'b0;
        repeat (3) step();
        chk("wr_cnt_ffff", 32'(wr_cnt), 32'h0000_FFFF);
        send(1'b1, 8'h05, 32'h1234_5678);
        req_valid = 1'b0;
        repeat (3) step();
        chk("wr_cnt_wrap", 32'(wr_cnt), 32'd0);
        chk("wrap_rd_cnt", 32'(rd_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
